// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// One operation in flight; result returned on the granted port with valid/ready.
module alu_arbiter #(
   parameter int unsigned WORD_SIZE   = 8,
   parameter int unsigned ALU_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [3:0]           req0_op,
   input  logic [WORD_SIZE-1:0] req0_in1,
   input  logic [WORD_SIZE-1:0] req0_in2,
   output logic                 resp0_valid,
   input  logic                 resp0_ready,
   output logic [WORD_SIZE-1:0] resp0_data,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [3:0]           req1_op,
   input  logic [WORD_SIZE-1:0] req1_in1,
   input  logic [WORD_SIZE-1:0] req1_in2,
   output logic                 resp1_valid,
   input  logic                 resp1_ready,
   output logic [WORD_SIZE-1:0] resp1_data,
   output logic [3:0]           alu_op,
   output logic [WORD_SIZE-1:0] alu_in1,
   output logic [WORD_SIZE-1:0] alu_in2,
   output logic                 alu_enable,
   input  logic [WORD_SIZE-1:0] alu_out
);

   localparam int unsigned OP_W  = 4;
   localparam int unsigned CNT_W = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic                 last_grant_q, last_grant_d;
   logic                 owner_q, owner_d;
   logic [OP_W-1:0]      op_q, op_d;
   logic [WORD_SIZE-1:0] in1_q, in1_d;
   logic [WORD_SIZE-1:0] in2_q, in2_d;
   logic                 alu_enable_q, alu_enable_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 resp0_valid_q, resp0_valid_d;
   logic                 resp1_valid_q, resp1_valid_d;
   logic [WORD_SIZE-1:0] resp0_data_q, resp0_data_d;
   logic [WORD_SIZE-1:0] resp1_data_q, resp1_data_d;

   logic grant0_c, grant1_c, owner_ready_c;

   // On contention the port that did not win last time gets the ALU.
   assign grant0_c = (state_q == S_IDLE) && req0_valid && (!req1_valid || last_grant_q);
   assign grant1_c = (state_q == S_IDLE) && req1_valid && (!req0_valid || !last_grant_q);
   assign owner_ready_c = owner_q ? resp1_ready : resp0_ready;

   assign req0_ready  = grant0_c;
   assign req1_ready  = grant1_c;
   assign resp0_valid = resp0_valid_q;
   assign resp1_valid = resp1_valid_q;
   assign resp0_data  = resp0_data_q;
   assign resp1_data  = resp1_data_q;
   assign alu_op      = op_q;
   assign alu_in1     = in1_q;
   assign alu_in2     = in2_q;
   assign alu_enable  = alu_enable_q;

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      owner_d       = owner_q;
      op_d          = op_q;
      in1_d         = in1_q;
      in2_d         = in2_q;
      alu_enable_d  = 1'b0;
      cnt_d         = cnt_q;
      resp0_valid_d = resp0_valid_q;
      resp1_valid_d = resp1_valid_q;
      resp0_data_d  = resp0_data_q;
      resp1_data_d  = resp1_data_q;
      case (state_q)
         S_IDLE: begin
            if (grant0_c || grant1_c) begin
               owner_d      = grant1_c;
               last_grant_d = grant1_c;
               op_d         = grant1_c ? req1_op  : req0_op;
               in1_d        = grant1_c ? req1_in1 : req0_in1;
               in2_d        = grant1_c ? req1_in2 : req0_in2;
               alu_enable_d = 1'b1;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CNT_W'(ALU_LATENCY);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Count reaching 1 means alu_out now holds this operation's result.
            if (cnt_q == CNT_W'(1)) begin
               if (owner_q) begin
                  resp1_data_d  = alu_out;
                  resp1_valid_d = 1'b1;
               end else begin
                  resp0_data_d  = alu_out;
                  resp0_valid_d = 1'b1;
               end
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            if (owner_ready_c) begin
               resp0_valid_d = 1'b0;
               resp1_valid_d = 1'b0;
               state_d       = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         last_grant_q  <= 1'b1;
         owner_q       <= 1'b0;
         op_q          <= '0;
         in1_q         <= '0;
         in2_q         <= '0;
         alu_enable_q  <= 1'b0;
         cnt_q         <= '0;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
         resp0_data_q  <= '0;
         resp1_data_q  <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         owner_q       <= owner_d;
         op_q          <= op_d;
         in1_q         <= in1_d;
         in2_q         <= in2_d;
         alu_enable_q  <= alu_enable_d;
         cnt_q         <= cnt_d;
         resp0_valid_q <= resp0_valid_d;
         resp1_valid_q <= resp1_valid_d;
         resp0_data_q  <= resp0_data_d;
         resp1_data_q  <= resp1_data_d;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-timestamp model checked every cycle,
// plus directed literal checks; a second instance covers ALU_LATENCY=3.
module tb_alu_arbiter;

   localparam int unsigned LAT = 1;
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;

   logic       clk, rst_n;
   logic       req0_valid, req1_valid, resp0_ready, resp1_ready;
   logic [3:0] req0_op, req1_op;
   logic [7:0] req0_in1, req0_in2, req1_in1, req1_in2;
   logic       req0_ready, req1_ready, resp0_valid, resp1_valid, alu_enable;
   logic [7:0] resp0_data, resp1_data, alu_in1, alu_in2, alu_out;
   logic [3:0] alu_op;
   logic       req0_ready_3, req1_ready_3, resp0_valid_3, resp1_valid_3, alu_enable_3;
   logic [7:0] resp0_data_3, resp1_data_3, alu_in1_3, alu_in2_3, alu_out_3;
   logic [3:0] alu_op_3;
   logic [7:0] pipe3 [3];

   int total = 0;
   int bad   = 0;
   int cyc;

   alu_arbiter #(.WORD_SIZE(8), .ALU_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_in1(req0_in1), .req0_in2(req0_in2),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_in1(req1_in1), .req1_in2(req1_in2),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
      .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_enable(alu_enable), .alu_out(alu_out));

   alu_arbiter #(.WORD_SIZE(8), .ALU_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready_3), .req0_op(req0_op),
      .req0_in1(req0_in1), .req0_in2(req0_in2),
      .resp0_valid(resp0_valid_3), .resp0_ready(resp0_ready), .resp0_data(resp0_data_3),
      .req1_valid(req1_valid), .req1_ready(req1_ready_3), .req1_op(req1_op),
      .req1_in1(req1_in1), .req1_in2(req1_in2),
      .resp1_valid(resp1_valid_3), .resp1_ready(resp1_ready), .resp1_data(resp1_data_3),
      .alu_op(alu_op_3), .alu_in1(alu_in1_3), .alu_in2(alu_in2_3),
      .alu_enable(alu_enable_3), .alu_out(alu_out_3));

   function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         4'h0:    return a + b;
         4'h1:    return a - b;
         4'h2:    return a & b;
         4'h3:    return a | b;
         4'h4:    return a ^ b;
         default: return a;
      endcase
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in ALUs: one-cycle and three-cycle registered result.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) alu_out <= 8'h00;
      else if (alu_enable) alu_out <= alu_f(alu_op, alu_in1, alu_in2);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) pipe3[i] <= 8'h00;
      end else begin
         if (alu_enable_3) pipe3[0] <= alu_f(alu_op_3, alu_in1_3, alu_in2_3);
         pipe3[1] <= pipe3[0];
         pipe3[2] <= pipe3[1];
      end
   end
   assign alu_out_3 = pipe3[2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else cyc <= cyc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: an operation accepted on edge A issues in cycle A, responds from
   // cycle A+1+LAT until the owner's ready is seen, and blocks new grants meanwhile.
   logic       m_busy, m_owner, m_last;
   int         m_acc;
   logic [3:0] m_op;
   logic [7:0] m_in1, m_in2, m_res;
   logic [7:0] m_data [2];

   always @(negedge clk) begin
      logic w0, w1, en_e, rphase;
      if (!rst_n) begin
         m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_acc = 0;
         m_op = 4'h0; m_in1 = 8'h00; m_in2 = 8'h00; m_res = 8'h00;
         m_data[0] = 8'h00; m_data[1] = 8'h00;
         chk("rst_outs", {req0_ready, req1_ready, resp0_valid, resp1_valid, alu_enable,
                          alu_op, alu_in1, alu_in2, resp0_data, resp1_data}, 32'h0);
      end else begin
         en_e   = m_busy && (cyc == m_acc);
         rphase = m_busy && (cyc >= m_acc + 1 + int'(LAT));
         if (m_busy && cyc == m_acc + 1 + int'(LAT)) m_data[m_owner] = m_res;
         w0 = !m_busy && req0_valid && (!req1_valid || m_last);
         w1 = !m_busy && req1_valid && (!req0_valid || !m_last);
         chk("m_req0_ready", 32'(req0_ready), 32'(w0));
         chk("m_req1_ready", 32'(req1_ready), 32'(w1));
         chk("m_alu_enable", 32'(alu_enable), 32'(en_e));
         chk("m_alu_bus", {12'h0, alu_op, alu_in1, alu_in2}, {12'h0, m_op, m_in1, m_in2});
         chk("m_resp0_valid", 32'(resp0_valid), 32'(rphase && !m_owner));
         chk("m_resp1_valid", 32'(resp1_valid), 32'(rphase && m_owner));
         chk("m_resp0_data", 32'(resp0_data), 32'(m_data[0]));
         chk("m_resp1_data", 32'(resp1_data), 32'(m_data[1]));
         if (w0 || w1) begin
            m_owner = w1; m_last = w1;
            m_op  = w1 ? req1_op  : req0_op;
            m_in1 = w1 ? req1_in1 : req0_in1;
            m_in2 = w1 ? req1_in2 : req0_in2;
            m_res = alu_f(m_op, m_in1, m_in2);
            m_acc = cyc + 1;
            m_busy = 1'b1;
         end else if (rphase && (m_owner ? resp1_ready : resp0_ready)) begin
            m_busy = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Waits (bounded) until the given port is granted; next edge is the accept.
   task automatic wait_ready(input int port, input string nm);
      bit got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if ((port == 0) ? req0_ready : req1_ready) got = 1'b1;
         else tick(1);
      end
      chk(nm, 32'(got), 32'h1);
   endtask

   initial begin
      int w;
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b1; resp1_ready = 1'b1;
      req0_op = 4'h0; req0_in1 = 8'h00; req0_in2 = 8'h00;
      req1_op = 4'h0; req1_in1 = 8'h00; req1_in2 = 8'h00;
      #1;
      chk("reset_outs", {resp0_valid, resp1_valid, alu_enable, alu_in1, resp0_data}, 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Reset while an operation is in WAIT drops it.
      req1_valid = 1'b1; req1_op = OP_ADD; req1_in1 = 8'h03; req1_in2 = 8'h04;
      wait_ready(1, "t1_grant");
      tick(1);
      req1_valid = 1'b0;
      tick(1);
      rst_n = 1'b0;
      #1;
      chk("t1_async_clear", {alu_enable, resp1_valid, alu_in1, alu_in2, alu_op}, 32'h0);
      tick(1);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("t1_no_resp", {30'h0, resp0_valid, resp1_valid}, 32'h0);
      end

      // Single request on port 0: 0x12 + 0x34.
      req0_valid = 1'b1; req0_op = OP_ADD; req0_in1 = 8'h12; req0_in2 = 8'h34;
      wait_ready(0, "t2_grant");
      tick(1);
      req0_valid = 1'b0;
      tick(1);
      chk("t2_valid_early", 32'(resp0_valid), 32'h0);
      tick(1);
      chk("t2_valid", 32'(resp0_valid), 32'h1);
      chk("t2_data", 32'(resp0_data), 32'h46);
      chk("t2_resp1_quiet", 32'(resp1_valid), 32'h0);
      tick(1);
      chk("t2_released", 32'(resp0_valid), 32'h0);
      chk("t2_data_held", 32'(resp0_data), 32'h46);

      // Both ports always valid: grants alternate starting with port 0.
      rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
      req0_valid = 1'b1; req0_op = OP_ADD; req0_in1 = 8'h01; req0_in2 = 8'h01;
      req1_valid = 1'b1; req1_op = OP_ADD; req1_in1 = 8'h02; req1_in2 = 8'h02;
      for (int k = 0; k < 4; k++) begin
         w = -1;
         for (int i = 0; i < 20 && w < 0; i++) begin
            #1;
            if (req0_ready) w = 0;
            else if (req1_ready) w = 1;
            else tick(1);
         end
         chk("t3_grant_order", 32'(w), 32'(k % 2));
         tick(1);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick(4);
      chk("t3_res0", 32'(resp0_data), 32'h02);
      chk("t3_res1", 32'(resp1_data), 32'h04);

      // Backpressure on port 1 with port 0 waiting.
      resp1_ready = 1'b0;
      req1_valid = 1'b1; req1_op = OP_ADD; req1_in1 = 8'h10; req1_in2 = 8'h20;
      wait_ready(1, "t4_grant1");
      tick(1);
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_op = OP_SUB; req0_in1 = 8'h50; req0_in2 = 8'h10;
      for (int i = 0; i < 10 && !resp1_valid; i++) tick(1);
      chk("t4_resp1_seen", 32'(resp1_valid), 32'h1);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4_hold", {15'h0, resp1_valid, req0_ready, resp1_data, 7'h0}, {15'h0, 1'b1, 1'b0, 8'h30, 7'h0});
         tick(1);
      end
      resp1_ready = 1'b1;
      tick(1);
      #1;
      chk("t4_resume", {30'h0, req0_ready, resp1_valid}, 32'h2);
      tick(1);
      req0_valid = 1'b0;
      tick(2);
      chk("t4_res0", {23'h0, resp0_valid, resp0_data}, {23'h0, 1'b1, 8'h40});
      tick(2);

      // Wrap-around.
      req0_valid = 1'b1; req0_op = OP_ADD; req0_in1 = 8'hFF; req0_in2 = 8'h02;
      wait_ready(0, "t5_grant");
      tick(1);
      req0_valid = 1'b0;
      tick(2);
      chk("t5_wrap", {23'h0, resp0_valid, resp0_data}, {23'h0, 1'b1, 8'h01});
      tick(2);

      // Three-cycle ALU: response four cycles after accept.
      rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
      req0_valid = 1'b1; req0_op = OP_ADD; req0_in1 = 8'h07; req0_in2 = 8'h08;
      wait_ready(0, "t5b_grant");
      chk("t5b_grant3", 32'(req0_ready_3), 32'h1);
      tick(1);
      req0_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick(1);
         chk("t5b_not_yet", 32'(resp0_valid_3), 32'h0);
      end
      tick(1);
      chk("t5b_lat3", {23'h0, resp0_valid_3, resp0_data_3}, {23'h0, 1'b1, 8'h0F});
      tick(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
